aes128: RTL and testbench

Iterative AES-128 (FIPS-197) engine: encrypts or decrypts one 128-bit block with a 128-bit key and computes one round per clock. Round keys are generated on the fly, so the block stores no key schedule. It is a self-contained crypto datapath with a level-enable/done handshake.

---
 rtl/aes128_pkg.sv | 68 ++++++
 rtl/aes128_key_step.sv | 50 +++++
 rtl/aes128.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_aes128.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/aes128_pkg.sv
// aes128_pkg: shared definitions for the iterative AES-128 engine.
//   - SBOX / INV_SBOX tables with sbox()/inv_sbox() lookup helpers
//   - xtime(): GF(2^8) multiply-by-2 modulo 0x11b
//   - RCON: round constants for the forward key schedule
//   - aesState_e: controller states; keyDir_e: key step direction
package aes128_pkg;

  localparam int NUM_ROUNDS = 10;

  typedef enum logic [2:0] {IDLE, LOAD, KEXP, ROUND, DONE} aesState_e;

  typedef enum logic {DIR_FWD, DIR_INV} keyDir_e;

  localparam logic [7:0] RCON [0:NUM_ROUNDS-1] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  localparam logic [7:0] INV_SBOX [0:255] = '{
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX[x];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes128_key_step.sv
// aes128_key_step: one AES-128 key-schedule step, purely combinational.
//   rk_in  [127:0]  current round key
//   rcon   [7:0]    round constant for this step
//   dir             DIR_FWD: rk_in = rk[i] -> rk_out = rk[i+1]
//                   DIR_INV: rk_in = rk[i+1] -> rk_out = rk[i]
//   rk_out [127:0]  adjacent round key
// The inverse direction exists only when AES128_DECRYPT_EN is defined;
// otherwise dir is ignored and the step is always forward.
module aes128_key_step
  import aes128_pkg::*;
(
  input  logic [127:0] rk_in,
  input  logic [7:0]   rcon,
  input  keyDir_e      dir,
  output logic [127:0] rk_out
);

  // RotWord followed by SubWord on the last word of the key.
  function automatic logic [31:0] subRotWord(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] fwd0, fwd1, fwd2, fwd3;

  assign {w0, w1, w2, w3} = rk_in;

  assign fwd0 = w0 ^ subRotWord(w3) ^ {rcon, 24'h0};
  assign fwd1 = w1 ^ fwd0;
  assign fwd2 = w2 ^ fwd1;
  assign fwd3 = w3 ^ fwd2;

`ifdef AES128_DECRYPT_EN
  // Undo the XOR chain from the top word down; the recovered last word
  // then feeds the same RotWord/SubWord term to recover the first word.
  logic [31:0] inv0, inv1, inv2, inv3;

  assign inv3 = w3 ^ w2;
  assign inv2 = w2 ^ w1;
  assign inv1 = w1 ^ w0;
  assign inv0 = w0 ^ subRotWord(inv3) ^ {rcon, 24'h0};

  assign rk_out = (dir == DIR_INV) ? {inv0, inv1, inv2, inv3} : {fwd0, fwd1, fwd2, fwd3};
`else
  logic unusedDir;
  assign unusedDir = dir;
  assign rk_out = {fwd0, fwd1, fwd2, fwd3};
`endif

endmodule

// File: rtl/aes128.sv
// aes128: iterative AES-128 engine, one round per clock, round keys
// generated on the fly by a single aes128_key_step instance.
//   clk                  rising-edge clock
//   reset                asynchronous active-low reset
//   enable               level request (1 = run/hold, 0 = idle)
//   mode                 0 = encrypt, 1 = decrypt
//   key      [127:0]     cipher key, byte 0 in [127:120]
//   data_in  [127:0]     input block, same byte order
//   data_out [127:0]     registered result
//   done                 registered result-valid level
// Build option AES128_DECRYPT_EN: include the decrypt path. Without it
// mode is ignored and every operation encrypts.
module aes128
  import aes128_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         mode,
  input  logic [127:0] key,
  input  logic [127:0] data_in,
  output logic [127:0] data_out,
  output logic         done
);

  // Byte i of the block sits at [127-8*i -: 8]; column c holds bytes 4c..4c+3.
  function automatic logic [127:0] subBytes(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(s[8*i +: 8]);
    return r;
  endfunction

  function automatic logic [127:0] shiftRows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++)
        r[127 - 8*(4*c + row) -: 8] = s[127 - 8*(4*((c + row) % 4) + row) -: 8];
    return r;
  endfunction

  function automatic logic [31:0] mixCol(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31 - 8*i -: 8];
      x2[i] = xtime(a[i]);
    end
    return {x2[0] ^ x2[1] ^ a[1] ^ a[2] ^ a[3],
            a[0] ^ x2[1] ^ x2[2] ^ a[2] ^ a[3],
            a[0] ^ a[1] ^ x2[2] ^ x2[3] ^ a[3],
            x2[0] ^ a[0] ^ a[1] ^ a[2] ^ x2[3]};
  endfunction

  function automatic logic [127:0] mixColumns(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) r[127 - 32*c -: 32] = mixCol(s[127 - 32*c -: 32]);
    return r;
  endfunction

  // MixColumns is skipped in the final round.
  function automatic logic [127:0] encRound(input logic [127:0] s, input logic [127:0] rk,
                                            input logic last);
    logic [127:0] r;
    r = shiftRows(subBytes(s));
    if (!last) r = mixColumns(r);
    return r ^ rk;
  endfunction

`ifdef AES128_DECRYPT_EN
  function automatic logic [127:0] invSubBytes(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_sbox(s[8*i +: 8]);
    return r;
  endfunction

  function automatic logic [127:0] invShiftRows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++)
        r[127 - 8*(4*c + row) -: 8] = s[127 - 8*(4*((c - row + 4) % 4) + row) -: 8];
    return r;
  endfunction

  // Multiples 9, 11, 13, 14 built from repeated xtime.
  function automatic logic [31:0] invMixCol(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] m11 [4];
    logic [7:0] m13 [4];
    logic [7:0] m14 [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]   = col[31 - 8*i -: 8];
      x2     = xtime(a[i]);
      x4     = xtime(x2);
      x8     = xtime(x4);
      m9[i]  = x8 ^ a[i];
      m11[i] = x8 ^ x2 ^ a[i];
      m13[i] = x8 ^ x4 ^ a[i];
      m14[i] = x8 ^ x4 ^ x2;
    end
    return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
            m9[0] ^ m14[1] ^ m11[2] ^ m13[3],
            m13[0] ^ m9[1] ^ m14[2] ^ m11[3],
            m11[0] ^ m13[1] ^ m9[2] ^ m14[3]};
  endfunction

  function automatic logic [127:0] invMixColumns(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) r[127 - 32*c -: 32] = invMixCol(s[127 - 32*c -: 32]);
    return r;
  endfunction

  // InvMixColumns is skipped after round key 0.
  function automatic logic [127:0] decRound(input logic [127:0] s, input logic [127:0] rk,
                                            input logic last);
    logic [127:0] r;
    r = invSubBytes(invShiftRows(s)) ^ rk;
    if (!last) r = invMixColumns(r);
    return r;
  endfunction
`endif

  aesState_e    fsm_q, fsm_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] rkey_q, rkey_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] capKey_q, capKey_d;
  logic [127:0] capData_q, capData_d;
  logic [127:0] dataOut_q, dataOut_d;
  logic         done_q, done_d;

  logic         isDec;
  logic         inputsChanged;
  logic         lastRound;
  logic [127:0] roundOut;
  logic [127:0] stepOut;
  logic [7:0]   stepRcon;
  logic [3:0]   rconIdx;
  keyDir_e      stepDir;

`ifdef AES128_DECRYPT_EN
  logic capMode_q, capMode_d;

  assign isDec         = capMode_q;
  assign inputsChanged = {mode, key, data_in} != {capMode_q, capKey_q, capData_q};
  assign lastRound     = capMode_q ? (round_q == 4'd0) : (round_q == 4'(NUM_ROUNDS));
  assign roundOut      = capMode_q ? decRound(blk_q, stepOut, lastRound)
                                   : encRound(blk_q, stepOut, lastRound);
`else
  logic unusedMode;

  assign unusedMode    = mode;
  assign isDec         = 1'b0;
  assign inputsChanged = {key, data_in} != {capKey_q, capData_q};
  assign lastRound     = (round_q == 4'(NUM_ROUNDS));
  assign roundOut      = encRound(blk_q, stepOut, lastRound);
`endif

  // Encrypt round r derives rk[r] from rk[r-1] with RCON[r-1]. Key expansion
  // and decrypt round r both use RCON[r]: forward rk[r] -> rk[r+1], inverse
  // rk[r+1] -> rk[r].
  always_comb begin
    stepDir = DIR_FWD;
    rconIdx = round_q - 4'd1;
    if (fsm_q == KEXP || (fsm_q == ROUND && isDec)) rconIdx = round_q;
    if (fsm_q == ROUND && isDec) stepDir = DIR_INV;
  end

  assign stepRcon = (rconIdx < 4'(NUM_ROUNDS)) ? RCON[rconIdx] : 8'h00;

  aes128_key_step u_keyStep (
    .rk_in  (rkey_q),
    .rcon   (stepRcon),
    .dir    (stepDir),
    .rk_out (stepOut)
  );

  always_comb begin
    fsm_d     = fsm_q;
    blk_d     = blk_q;
    rkey_d    = rkey_q;
    round_d   = round_q;
    capKey_d  = capKey_q;
    capData_d = capData_q;
    dataOut_d = dataOut_q;
    done_d    = done_q;
`ifdef AES128_DECRYPT_EN
    capMode_d = capMode_q;
`endif

    if (!enable) begin
      fsm_d  = IDLE;
      done_d = 1'b0;
    end else if (fsm_q == IDLE || inputsChanged) begin
      // Fresh start or restart: recapture the live inputs.
      capKey_d  = key;
      capData_d = data_in;
`ifdef AES128_DECRYPT_EN
      capMode_d = mode;
`endif
      done_d    = 1'b0;
      fsm_d     = LOAD;
    end else begin
      unique case (fsm_q)
        LOAD: begin
          rkey_d = capKey_q;
          if (isDec) begin
            round_d = 4'd0;
            fsm_d   = KEXP;
          end else begin
            blk_d   = capData_q ^ capKey_q;
            round_d = 4'd1;
            fsm_d   = ROUND;
          end
        end
`ifdef AES128_DECRYPT_EN
        KEXP: begin
          // Ten forward steps reach rk[10], then one cycle for the initial AddRoundKey.
          if (round_q < 4'(NUM_ROUNDS)) begin
            rkey_d  = stepOut;
            round_d = round_q + 4'd1;
          end else begin
            blk_d   = capData_q ^ rkey_q;
            round_d = 4'(NUM_ROUNDS - 1);
            fsm_d   = ROUND;
          end
        end
`endif
        ROUND: begin
          rkey_d = stepOut;
          blk_d  = roundOut;
          if (lastRound) begin
            dataOut_d = roundOut;
            done_d    = 1'b1;
            fsm_d     = DONE;
          end else begin
            round_d = isDec ? round_q - 4'd1 : round_q + 4'd1;
          end
        end
        DONE: begin
          done_d = 1'b1;
        end
        default: begin
          fsm_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q     <= IDLE;
      blk_q     <= '0;
      rkey_q    <= '0;
      round_q   <= '0;
      capKey_q  <= '0;
      capData_q <= '0;
      dataOut_q <= '0;
      done_q    <= 1'b0;
`ifdef AES128_DECRYPT_EN
      capMode_q <= 1'b0;
`endif
    end else begin
      fsm_q     <= fsm_d;
      blk_q     <= blk_d;
      rkey_q    <= rkey_d;
      round_q   <= round_d;
      capKey_q  <= capKey_d;
      capData_q <= capData_d;
      dataOut_q <= dataOut_d;
      done_q    <= done_d;
`ifdef AES128_DECRYPT_EN
      capMode_q <= capMode_d;
`endif
    end
  end

  assign data_out = dataOut_q;
  assign done     = done_q;

endmodule

// File: tb/tb_aes128.sv
// tb_aes128: directed, scoreboard-based bench for aes128. Expected blocks
// are queued as stimulus is applied and popped when done rises. Decrypt
// expectations are used only when AES128_DECRYPT_EN is defined.
module tb_aes128;

  localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] ZERO = 128'h0;
  localparam logic [127:0] CTZ  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam int ENC_LAT = 12;
  localparam int DEC_LAT = 23;
  localparam int TIMEOUT = 60;

  logic         clk;
  logic         reset;
  logic         enable;
  logic         mode;
  logic [127:0] key;
  logic [127:0] dataIn;
  logic [127:0] dataOut;
  logic         done;

  int           checks = 0;
  int           failures = 0;
  int           edges;
  logic [127:0] expQ [$];

  aes128 dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .mode     (mode),
    .key      (key),
    .data_in  (dataIn),
    .data_out (dataOut),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Inputs change on the falling edge, away from the sampling edge.
  task automatic applyStimulus(input logic en, input logic md, input logic [127:0] k,
                               input logic [127:0] d);
    @(negedge clk);
    enable = en;
    mode   = md;
    key    = k;
    dataIn = d;
  endtask

  // Counts rising edges (the first one being the edge that samples the
  // new stimulus) until done is seen, bounded by TIMEOUT.
  task automatic waitDone(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (done !== 1'b1 && n < TIMEOUT);
  endtask

  task automatic checkResult(input string tag, input int expLat);
    logic [127:0] expVal;
    waitDone(edges);
    checkOutput({tag, " latency"}, 128'(edges), 128'(expLat));
    expVal = (expQ.size() > 0) ? expQ.pop_front() : 128'hx;
    checkOutput({tag, " data"}, dataOut, expVal);
  endtask

  initial begin
    reset  = 1'b0;
    enable = 1'b0;
    mode   = 1'b0;
    key    = '0;
    dataIn = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset data_out", dataOut, ZERO);
    checkOutput("reset done", 128'(done), 128'd1 - 128'd1);
    @(negedge clk);
    reset = 1'b1;

    $display("[TB] encrypt FIPS-197 vector");
    applyStimulus(1'b1, 1'b0, KEY1, PT1);
    expQ.push_back(CT1);
    checkResult("enc1", ENC_LAT);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("hold done", 128'(done), 128'd1);
    checkOutput("hold data", dataOut, CT1);

    applyStimulus(1'b0, 1'b0, KEY1, PT1);
    @(posedge clk);
    #1;
    checkOutput("disable done", 128'(done), 128'd0);
    checkOutput("disable data", dataOut, CT1);

    $display("[TB] re-enable with same inputs");
    applyStimulus(1'b1, 1'b0, KEY1, PT1);
    expQ.push_back(CT1);
    checkResult("reenable", ENC_LAT);

    $display("[TB] all-zero encrypt");
    applyStimulus(1'b1, 1'b0, ZERO, ZERO);
    expQ.push_back(CTZ);
    checkResult("enczero", ENC_LAT);

    $display("[TB] input change during run");
    applyStimulus(1'b1, 1'b0, KEY1, PT1);
    @(posedge clk);
    #1;
    checkOutput("change done drop", 128'(done), 128'd0);
`ifdef AES128_DECRYPT_EN
    applyStimulus(1'b1, 1'b1, KEY1, CT1);
    expQ.push_back(PT1);
    checkResult("change dec", DEC_LAT);
`else
    applyStimulus(1'b1, 1'b1, ZERO, ZERO);
    expQ.push_back(CTZ);
    checkResult("change enc", ENC_LAT);
`endif

    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, 1'b0, KEY1, PT1);
    repeat (6) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midreset data_out", dataOut, ZERO);
    checkOutput("midreset done", 128'(done), 128'd0);
    @(negedge clk);
    reset = 1'b1;
    expQ.push_back(CT1);
    checkResult("afterreset", ENC_LAT);

`ifdef AES128_DECRYPT_EN
    $display("[TB] all-zero-key decrypt");
    applyStimulus(1'b1, 1'b1, ZERO, CTZ);
    expQ.push_back(ZERO);
    checkResult("deczero", DEC_LAT);
`else
    $display("[TB] mode-only change is ignored");
    applyStimulus(1'b1, 1'b1, KEY1, PT1);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("modeonly done", 128'(done), 128'd1);
    checkOutput("modeonly data", dataOut, CT1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
